// File: rtl/rece_crc_strip.sv
// rtl/rece_crc_strip.sv - receive CRC-32 check with 4-byte trailer strip
module rece_crc_strip #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_axis_tvalid,
    input  logic [31:0]      s_axis_tdata,
    input  logic [3:0]       s_axis_tkeep,
    input  logic             s_axis_tlast,
    output logic             receCrcOut_tvalid,
    output logic [31:0]      receCrcOut_tdata,
    output logic [3:0]       receCrcOut_tkeep,
    output logic             receCrcOut_tlast,
    output logic             receCrcOut_crcOk,
    output logic             receCrcOut_crcErr,
    output logic             short_err,
    output logic [CNT_W-1:0] crc_ok_cnt,
    output logic [CNT_W-1:0] crc_err_cnt
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       crc_q, crc_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [3:0]        out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              short_q, short_d;
    logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic [2:0]        k;
    logic [31:0]       crc_next;
    logic              crc_good;
    logic [31:0]       trunc_mask;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int j = 0; j < 8; j++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        k = 3'd4;
        if (s_axis_tlast && s_axis_tkeep != 4'd0 && s_axis_tkeep <= 4'd4) begin
            k = s_axis_tkeep[2:0];
        end

        crc_next = crc_q;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < k) begin
                crc_next = crc_byte(crc_next, s_axis_tdata[31-8*i -: 8]);
            end
        end
        crc_good   = (crc_next == CRC_RESIDUE);
        // Held word carries k payload bytes when the last beat has k<4 bytes.
        trunc_mask = ~(32'hFFFFFFFF >> {k, 3'b000});

        state_d     = state_q;
        hold_d      = hold_q;
        crc_d       = crc_q;
        out_valid_d = 1'b0;
        out_data_d  = 32'd0;
        out_keep_d  = 4'd0;
        out_last_d  = 1'b0;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        short_d     = 1'b0;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (s_axis_tvalid) begin
            crc_d = s_axis_tlast ? CRC_INIT : crc_next;
            case (state_q)
                IDLE: begin
                    if (s_axis_tlast) begin
                        short_d = 1'b1;
                    end else begin
                        hold_d  = s_axis_tdata;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    out_valid_d = 1'b1;
                    if (!s_axis_tlast) begin
                        out_data_d = hold_q;
                        out_keep_d = 4'd4;
                        hold_d     = s_axis_tdata;
                    end else begin
                        out_data_d = hold_q & trunc_mask;
                        out_keep_d = {1'b0, k};
                        out_last_d = 1'b1;
                        ok_d       = crc_good;
                        err_d      = !crc_good;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (ok_d && ok_cnt_q != '1) begin
            ok_cnt_d = ok_cnt_q + 1'b1;
        end
        if ((err_d || short_d) && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 32'd0;
            crc_q       <= CRC_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_keep_q  <= 4'd0;
            out_last_q  <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            short_q     <= 1'b0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            crc_q       <= crc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            short_q     <= short_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign receCrcOut_tvalid = out_valid_q;
    assign receCrcOut_tdata  = out_data_q;
    assign receCrcOut_tkeep  = out_keep_q;
    assign receCrcOut_tlast  = out_last_q;
    assign receCrcOut_crcOk  = ok_q;
    assign receCrcOut_crcErr = err_q;
    assign short_err         = short_q;
    assign crc_ok_cnt        = ok_cnt_q;
    assign crc_err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_rece_crc_strip.sv
// tb/tb_rece_crc_strip.sv - directed bench for rece_crc_strip
module tb_rece_crc_strip;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [31:0]   s_axis_tdata = 32'd0;
    logic [3:0]    s_axis_tkeep = 4'd0;
    logic          s_axis_tlast = 1'b0;
    logic          receCrcOut_tvalid;
    logic [31:0]   receCrcOut_tdata;
    logic [3:0]    receCrcOut_tkeep;
    logic          receCrcOut_tlast;
    logic          receCrcOut_crcOk;
    logic          receCrcOut_crcErr;
    logic          short_err;
    logic [CW-1:0] crc_ok_cnt;
    logic [CW-1:0] crc_err_cnt;

    int checks = 0;
    int failures = 0;

    rece_crc_strip #(.CNT_W(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .receCrcOut_tvalid (receCrcOut_tvalid),
        .receCrcOut_tdata  (receCrcOut_tdata),
        .receCrcOut_tkeep  (receCrcOut_tkeep),
        .receCrcOut_tlast  (receCrcOut_tlast),
        .receCrcOut_crcOk  (receCrcOut_crcOk),
        .receCrcOut_crcErr (receCrcOut_crcErr),
        .short_err         (short_err),
        .crc_ok_cnt        (crc_ok_cnt),
        .crc_err_cnt       (crc_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [40:0] ex(input logic v, input logic [31:0] d, input logic [3:0] k,
                                       input logic l, input logic ok, input logic er, input logic sh);
        return {v, d, k, l, ok, er, sh};
    endfunction

    function automatic logic [40:0] observed();
        return {receCrcOut_tvalid, receCrcOut_tdata, receCrcOut_tkeep, receCrcOut_tlast,
                receCrcOut_crcOk, receCrcOut_crcErr, short_err};
    endfunction

    function automatic logic [31:0] crc32_ref(input logic [63:0] msg);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            c = c ^ {24'd0, msg[63-8*i -: 8]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic [40:0] exp_out, input string tag);
        logic [40:0] obs;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_tkeep  = 4'd0;
        s_axis_tlast  = 1'b0;
        obs = observed();
        checks++;
        assert (obs === exp_out) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_out);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b0, 41'd0, tag);
    endtask

    task automatic chk_cnt(input logic [CW-1:0] eok, input logic [CW-1:0] eerr, input string tag);
        checks++;
        assert ({crc_ok_cnt, crc_err_cnt} === {eok, eerr}) else begin
            failures++;
            $error("FAIL %s observed ok=%0d err=%0d expected ok=%0d err=%0d",
                   tag, crc_ok_cnt, crc_err_cnt, eok, eerr);
        end
    endtask

    task automatic run_t1(input logic bad, input int gap, input string tag);
        logic [31:0] b2;
        b2 = bad ? 32'h34363738 : 32'h35363738;
        step(1'b1, 32'h31323334, 4'd4, 1'b0, ex(0, 32'h0, 4'd0, 0, 0, 0, 0), {tag, "_b1"});
        idle(gap, {tag, "_gap1"});
        step(1'b1, b2, 4'd4, 1'b0, ex(1, 32'h31323334, 4'd4, 0, 0, 0, 0), {tag, "_b2"});
        idle(gap, {tag, "_gap2"});
        step(1'b1, 32'h392639F4, 4'd4, 1'b0, ex(1, b2, 4'd4, 0, 0, 0, 0), {tag, "_b3"});
        idle(gap, {tag, "_gap3"});
        step(1'b1, 32'hCB000000, 4'd1, 1'b1, ex(1, 32'h39000000, 4'd1, 1, !bad, bad, 0), {tag, "_last"});
    endtask

    task automatic run_t3(input logic [3:0] last_keep, input string tag);
        logic [31:0] c;
        c = crc32_ref(64'h0102030405060708);
        step(1'b1, 32'h01020304, 4'd4, 1'b0, ex(0, 32'h0, 4'd0, 0, 0, 0, 0), {tag, "_b1"});
        step(1'b1, 32'h05060708, 4'd4, 1'b0, ex(1, 32'h01020304, 4'd4, 0, 0, 0, 0), {tag, "_b2"});
        step(1'b1, {c[7:0], c[15:8], c[23:16], c[31:24]}, last_keep, 1'b1,
             ex(1, 32'h05060708, 4'd4, 1, 1, 0, 0), {tag, "_last"});
        idle(1, {tag, "_after"});
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (observed() === 41'd0) else begin
            failures++;
            $error("FAIL reset_out observed=%h expected=%h", observed(), 41'd0);
        end
        chk_cnt(2'd0, 2'd0, "reset_cnt");
        rst_n = 1'b1;
        idle(1, "post_reset");

        run_t1(1'b0, 0, "t1");
        run_t1(1'b1, 0, "t2_b2b");
        idle(1, "t2_after");
        chk_cnt(2'd1, 2'd1, "cnt_t2");

        run_t3(4'd4, "t3");
        run_t3(4'd0, "t3_keep0");
        chk_cnt(2'd3, 2'd1, "cnt_t3");

        step(1'b1, 32'hAABBCCDD, 4'd4, 1'b1, ex(0, 32'h0, 4'd0, 0, 0, 0, 1), "t4_short");
        chk_cnt(2'd3, 2'd2, "cnt_t4");
        step(1'b1, 32'hAABBCCDD, 4'hF, 1'b1, ex(0, 32'h0, 4'd0, 0, 0, 0, 1), "t4_short2");
        step(1'b1, 32'h11223344, 4'd2, 1'b1, ex(0, 32'h0, 4'd0, 0, 0, 0, 1), "t4_short3");
        idle(1, "t4_after");
        chk_cnt(2'd3, 2'd3, "cnt_err_sat");

        run_t1(1'b0, 3, "t5_gaps");
        idle(1, "t5_after");
        chk_cnt(2'd3, 2'd3, "cnt_ok_sat");

        step(1'b1, 32'h31323334, 4'd4, 1'b0, ex(0, 32'h0, 4'd0, 0, 0, 0, 0), "t6_b1");
        step(1'b1, 32'h35363738, 4'd4, 1'b0, ex(1, 32'h31323334, 4'd4, 0, 0, 0, 0), "t6_b2");
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        assert (observed() === 41'd0) else begin
            failures++;
            $error("FAIL t6_reset_out observed=%h expected=%h", observed(), 41'd0);
        end
        chk_cnt(2'd0, 2'd0, "t6_reset_cnt");
        rst_n = 1'b1;
        run_t1(1'b0, 0, "t6_frame");
        idle(1, "t6_after");
        chk_cnt(2'd1, 2'd0, "cnt_t6");

        run_t1(1'b0, 1, "t7");
        idle(2, "t7_after");
        chk_cnt(2'd2, 2'd0, "cnt_t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
